sdram_wbm_tester: RTL and testbench

- Wishbone classic initiator that drives the SDRAM-access slave port of sdram_top: writes a seeded pattern over an address window, reads it back and checks it.
- Used as a bring-up/self-test master in simulation and on hardware. Status (done, errors, timeout) is exposed for the CSR block or a bench to sample.
- Single transaction outstanding; no bursts, no pipelined mode.

---
 rtl/sdram_wb_pkg.sv | 27 ++
 rtl/sdram_wbm_ack_timer.sv | 31 +++
 rtl/sdram_wbm_tester.sv | 161 ++++++++++++++++
 tb/tb_sdram_wbm_tester.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sdram_wb_pkg.sv
// Shared types and helpers for the SDRAM wishbone test masters.
// Combinational only: no latency.
// No flow control of its own.
package sdram_wb_pkg;

  localparam int ERR_CNT_W = 16;
  localparam int PAT_MAX_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_REQ = 3'd1,
    ST_WR_GAP = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_GAP = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  // Test pattern: word index XOR seed. Callers truncate the result to their
  // data width, which gives index[DW-1:0] ^ seed.
  function automatic logic [PAT_MAX_W-1:0] pattern_word(
    input logic [PAT_MAX_W-1:0] index,
    input logic [PAT_MAX_W-1:0] seed
  );
    return index ^ seed;
  endfunction

endpackage

// File: rtl/sdram_wbm_ack_timer.sv
// Loadable wait counter that flags when a bus request has waited too long.
// Expiry is combinational from the registered count: count reaches TIMEOUT-1.
// Counting stops at expiry; load has priority over enable.
module sdram_wbm_ack_timer #(
  parameter int TIMEOUT = 4096,
  parameter int CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          expired
);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  // Count request cycles; hold at the expiry value until reloaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sdram_wbm_tester.sv
// Wishbone classic self-test master: writes a seeded pattern over a window, reads back and checks.
// Zero-wait slave: 2 cycles per access, 4*NUM_WORDS+1 cycles from start to done.
// Each request held until ack or timeout; one idle bus cycle between accesses.
module sdram_wbm_tester
  import sdram_wb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 16,
  parameter int NUM_WORDS = 1024,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [DW-1:0]        seed,
  output logic [AW-1:0]        wbm_address,
  output logic [DW-1:0]        wbm_writedata,
  input  logic [DW-1:0]        wbm_readdata,
  output logic                 wbm_strobe,
  output logic                 wbm_cycle,
  output logic                 wbm_write,
  input  logic                 wbm_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [AW-1:0]        first_err_addr,
  output logic [DW-1:0]        first_err_data
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [AW-1:0] base_q;
  logic [DW-1:0] seed_q;
  logic [DW-1:0] wr_nxt;
  logic [DW-1:0] rd_expect;
  logic          in_req;
  logic          tmr_expired;

  assign idx_nxt   = idx + IW'(1);
  assign wr_nxt    = DW'(pattern_word(PAT_MAX_W'(idx_nxt), PAT_MAX_W'(seed_q)));
  assign rd_expect = DW'(pattern_word(PAT_MAX_W'(idx), PAT_MAX_W'(seed_q)));
  assign in_req    = (state == ST_WR_REQ) || (state == ST_RD_REQ);

  // Timer held at zero outside request states, so it restarts on every request.
  sdram_wbm_ack_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (TW)
  ) u_ack_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (!in_req),
    .load_val ('0),
    .en       (in_req),
    .expired  (tmr_expired)
  );

  // Run sequencer; all bus and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      wbm_address    <= '0;
      wbm_writedata  <= '0;
      wbm_strobe     <= 1'b0;
      wbm_cycle      <= 1'b0;
      wbm_write      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q         <= base_addr;
            seed_q         <= seed;
            idx            <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            timeout        <= 1'b0;
            busy           <= 1'b1;
            wbm_cycle      <= 1'b1;
            wbm_strobe     <= 1'b1;
            wbm_write      <= 1'b1;
            wbm_address    <= base_addr;
            wbm_writedata  <= DW'(pattern_word('0, PAT_MAX_W'(seed)));
            state          <= ST_WR_REQ;
          end
        end
        ST_WR_REQ, ST_RD_REQ: begin
          if (wbm_ack) begin
            wbm_cycle  <= 1'b0;
            wbm_strobe <= 1'b0;
            wbm_write  <= 1'b0;
            if (state == ST_RD_REQ && wbm_readdata != rd_expect) begin
              if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
              if (err_count == '0) begin
                first_err_addr <= wbm_address;
                first_err_data <= wbm_readdata;
              end
            end
            state <= (state == ST_WR_REQ) ? ST_WR_GAP : ST_RD_GAP;
          end else if (tmr_expired) begin
            wbm_cycle  <= 1'b0;
            wbm_strobe <= 1'b0;
            wbm_write  <= 1'b0;
            timeout    <= 1'b1;
            state      <= ST_FIN;
          end
        end
        ST_WR_GAP: begin
          wbm_cycle  <= 1'b1;
          wbm_strobe <= 1'b1;
          if (idx == LAST) begin
            idx         <= '0;
            wbm_write   <= 1'b0;
            wbm_address <= base_q;
            state       <= ST_RD_REQ;
          end else begin
            idx           <= idx_nxt;
            wbm_write     <= 1'b1;
            wbm_address   <= base_q + AW'(idx_nxt);
            wbm_writedata <= wr_nxt;
            state         <= ST_WR_REQ;
          end
        end
        ST_RD_GAP: begin
          if (idx == LAST) begin
            state <= ST_FIN;
          end else begin
            idx         <= idx_nxt;
            wbm_cycle   <= 1'b1;
            wbm_strobe  <= 1'b1;
            wbm_address <= base_q + AW'(idx_nxt);
            state       <= ST_RD_REQ;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wbm_tester.sv
module tb_sdram_wbm_tester;

  localparam int NW = 8;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [15:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] seed = '0;
  logic [31:0] wbm_address;
  logic [15:0] wbm_writedata;
  logic [15:0] wbm_readdata;
  logic        wbm_strobe, wbm_cycle, wbm_write, wbm_ack;
  logic        busy, done, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic [15:0] first_err_data;

  int   errors = 0;
  int   checks = 0;
  txn_t sb[$];
  logic [15:0] mem [0:255];
  int   wcnt = 0;
  int   wait_states = 0;
  bit   ack_en = 1'b1;
  bit   corrupt_en = 1'b0;
  bit   prev_ack = 1'b0;
  int   bus_hi_cnt = 0;
  int   rd_cnt = 0;

  sdram_wbm_tester #(
    .AW(32), .DW(16), .NUM_WORDS(NW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .seed(seed),
    .wbm_address(wbm_address), .wbm_writedata(wbm_writedata), .wbm_readdata(wbm_readdata),
    .wbm_strobe(wbm_strobe), .wbm_cycle(wbm_cycle), .wbm_write(wbm_write), .wbm_ack(wbm_ack),
    .busy(busy), .done(done), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responder: memory with programmable wait states and optional read corruption.
  assign wbm_ack = ack_en && wbm_cycle && wbm_strobe && (wcnt >= wait_states);
  assign wbm_readdata = (corrupt_en && wbm_address == 32'h103) ? 16'h0000 :
                        (corrupt_en && wbm_address == 32'h105) ? 16'h1234 :
                        mem[wbm_address[7:0]];

  always @(posedge clk) begin
    if (wbm_cycle && wbm_strobe && !wbm_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (wbm_ack && wbm_write) mem[wbm_address[7:0]] <= wbm_writedata;
  end

  // Monitor: compare every bus cycle against the scoreboard head, pop on ack.
  always @(negedge clk) begin
    if (prev_ack) chk("gap_after_ack", 64'(wbm_cycle), 64'(0));
    prev_ack = wbm_ack;
    if (wbm_cycle) bus_hi_cnt++;
    if (wbm_cycle && !wbm_write) rd_cnt++;
    if (wbm_cycle && wbm_strobe) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_txn: observed addr=%0h expected no bus cycle", wbm_address);
      end
      if (sb.size() > 0) begin
        chk("txn_addr", 64'(wbm_address), 64'(sb[0].addr));
        chk("txn_we", 64'(wbm_write), 64'(sb[0].we));
        if (sb[0].we) chk("txn_wdata", 64'(wbm_writedata), 64'(sb[0].data));
        if (wbm_ack) void'(sb.pop_front());
      end
    end
  end

  // Push expected transactions, start a run and wait (bounded) for done.
  task automatic do_run(input logic [31:0] base, input logic [15:0] sd,
                        input bit busy_start, output int cyc);
    bit got;
    sb.delete();
    for (int i = 0; i < NW; i++) sb.push_back('{1'b1, base + 32'(i), 16'(i) ^ sd});
    for (int i = 0; i < NW; i++) sb.push_back('{1'b0, base + 32'(i), 16'(i) ^ sd});
    bus_hi_cnt = 0;
    rd_cnt = 0;
    @(negedge clk);
    base_addr = base; seed = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    cyc = 0;
    got = 1'b0;
    while (cyc < 2000 && !got) begin
      @(negedge clk);
      cyc++;
      if (busy_start && cyc == 5) begin
        start = 1'b1; base_addr = 32'h200; seed = 16'h0;
      end
      if (busy_start && cyc == 6) start = 1'b0;
      got = done;
    end
  endtask

  task automatic check_status(input string tag, input int cyc, input int exp_cyc,
                              input logic [15:0] e_cnt, input logic [31:0] e_addr,
                              input logic [15:0] e_data, input logic e_to);
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_err_count"}, 64'(err_count), 64'(e_cnt));
    chk({tag, "_first_err_addr"}, 64'(first_err_addr), 64'(e_addr));
    chk({tag, "_first_err_data"}, 64'(first_err_data), 64'(e_data));
    chk({tag, "_timeout"}, 64'(timeout), 64'(e_to));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'(0));
  endtask

  initial begin
    int cyc;
    int done_seen;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cycle", 64'(wbm_cycle), 64'(0));
    chk("rst_strobe", 64'(wbm_strobe), 64'(0));
    chk("rst_address", 64'(wbm_address), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    reset = 1'b0;

    // Zero-wait pass run, with a start pulse while busy that must be ignored
    do_run(32'h100, 16'hA5A5, 1'b1, cyc);
    chk("pass_sb_empty", 64'(sb.size()), 64'(0));
    check_status("pass", cyc, 4 * NW + 1, 16'h0, 32'h0, 16'h0, 1'b0);

    // Three wait states per access: 5 cycles per access
    wait_states = 3;
    do_run(32'h100, 16'hA5A5, 1'b0, cyc);
    chk("wait_sb_empty", 64'(sb.size()), 64'(0));
    check_status("wait", cyc, 2 * NW * 5 + 1, 16'h0, 32'h0, 16'h0, 1'b0);
    wait_states = 0;

    // Corrupted reads at 0x103 and 0x105
    corrupt_en = 1'b1;
    do_run(32'h100, 16'hA5A5, 1'b0, cyc);
    check_status("corrupt", cyc, 4 * NW + 1, 16'd2, 32'h103, 16'h0000, 1'b0);
    corrupt_en = 1'b0;

    // No ack at all: bus held 16 cycles, then abort with timeout
    ack_en = 1'b0;
    do_run(32'h100, 16'hA5A5, 1'b0, cyc);
    chk("to_bus_cycles", 64'(bus_hi_cnt), 64'(16));
    chk("to_no_reads", 64'(rd_cnt), 64'(0));
    check_status("to", cyc, 17, 16'h0, 32'h0, 16'h0, 1'b1);
    ack_en = 1'b1;
    sb.delete();

    // Address window wrapping through 2^32
    do_run(32'hFFFF_FFFE, 16'h3C0F, 1'b0, cyc);
    chk("wrap_sb_empty", 64'(sb.size()), 64'(0));
    check_status("wrap", cyc, 4 * NW + 1, 16'h0, 32'h0, 16'h0, 1'b0);

    // Reset during read phase after two mismatches were recorded
    corrupt_en = 1'b1;
    sb.delete();
    for (int i = 0; i < NW; i++) sb.push_back('{1'b1, 32'h100 + 32'(i), 16'(i) ^ 16'h5A5A});
    for (int i = 0; i < NW; i++) sb.push_back('{1'b0, 32'h100 + 32'(i), 16'(i) ^ 16'h5A5A});
    @(negedge clk);
    base_addr = 32'h100; seed = 16'h5A5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_err_count", 64'(err_count), 64'(2));
    chk("mid_first_err_addr", 64'(first_err_addr), 64'(32'h103));
    chk("mid_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_cycle", 64'(wbm_cycle), 64'(0));
    chk("mrst_strobe", 64'(wbm_strobe), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_err_count", 64'(err_count), 64'(0));
    chk("mrst_first_err_addr", 64'(first_err_addr), 64'(0));
    chk("mrst_first_err_data", 64'(first_err_data), 64'(0));
    chk("mrst_timeout", 64'(timeout), 64'(0));
    reset = 1'b0;
    sb.delete();
    bus_hi_cnt = 0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("mrst_no_done", 64'(done_seen), 64'(0));
    chk("mrst_bus_idle", 64'(bus_hi_cnt), 64'(0));
    corrupt_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
